lc4_rename_ctrl: RTL and testbench

- Register-rename controller for the LC4 out-of-order core; sequences the 16-entry physical-register free list.
- Holds the speculative map (8 arch to 16 phys) and the committed map.
- Grants decode allocations, returns commit frees to the free list, and runs a 16-cycle recovery walk after a pipeline flush.
- Sits between decode/dispatch, the ROB commit port and the free list.

---
 rtl/lc4_rename_ctrl_if.sv | 44 ++++
 rtl/lc4_rename_ctrl.sv | 110 +++++++++++
 tb/tb_lc4_rename_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc4_rename_ctrl_if.sv
// Decode/rename, commit and free-list signal bundle for lc4_rename_ctrl.
// slave = rename controller side, master = decode/ROB/free-list side.
interface lc4_rename_ctrl_if #(
  parameter int unsigned WA = 3,
  parameter int unsigned WP = 4
) ();
  logic          dec_valid;
  logic          dec_dst_we;
  logic [WA-1:0] dec_dst;
  logic [WA-1:0] dec_src1;
  logic [WA-1:0] dec_src2;
  logic          dec_ready;
  logic [WP-1:0] ren_dst;
  logic [WP-1:0] ren_src1;
  logic [WP-1:0] ren_src2;
  logic [WP-1:0] ren_old_dst;
  logic          cmt_valid;
  logic          cmt_dst_we;
  logic [WA-1:0] cmt_arch;
  logic [WP-1:0] cmt_new_pr;
  logic [WP-1:0] cmt_old_pr;
  logic          fl_full;
  logic [WP-1:0] fl_next;
  logic          fl_alloc;
  logic          fl_dealloc;
  logic          fl_flush;
  logic [WP-1:0] fl_cpr;

  modport slave (
    input  dec_valid, dec_dst_we, dec_dst, dec_src1, dec_src2,
    input  cmt_valid, cmt_dst_we, cmt_arch, cmt_new_pr, cmt_old_pr,
    input  fl_full, fl_next,
    output dec_ready, ren_dst, ren_src1, ren_src2, ren_old_dst,
    output fl_alloc, fl_dealloc, fl_flush, fl_cpr
  );

  modport master (
    output dec_valid, dec_dst_we, dec_dst, dec_src1, dec_src2,
    output cmt_valid, cmt_dst_we, cmt_arch, cmt_new_pr, cmt_old_pr,
    output fl_full, fl_next,
    input  dec_ready, ren_dst, ren_src1, ren_src2, ren_old_dst,
    input  fl_alloc, fl_dealloc, fl_flush, fl_cpr
  );
endinterface

// File: rtl/lc4_rename_ctrl.sv
// LC4 register-rename controller: speculative/committed maps, free-list sequencing, flush recovery walk.
// Optional stall counter enabled by defining LC4_RENAME_STALL_CNT_EN.
module lc4_rename_ctrl #(
  parameter int unsigned NA = 8,
  parameter int unsigned NP = 16,
  parameter int unsigned WA = 3,
  parameter int unsigned WP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe,
  input  logic                 flush,
  lc4_rename_ctrl_if.slave     rn,
  output logic                 busy,
  output logic [15:0]          stall_cnt
);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t        state, state_nxt;
  logic [WP-1:0] cnt, cnt_nxt;
  logic [WP-1:0] spec_map [NA];
  logic [WP-1:0] cmt_map  [NA];
  logic          ready, alloc, dealloc, walk_done, in_cmt;
  logic [WP-1:0] cpr;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    alloc     = 1'b0;
    dealloc   = 1'b0;
    cpr       = '0;
    busy      = 1'b0;
    walk_done = 1'b0;
    in_cmt    = 1'b0;
    unique case (state)
      RUN: begin
        ready   = ~flush & (~rn.dec_dst_we | ~rn.fl_full);
        alloc   = rn.dec_valid & ready & rn.dec_dst_we;
        dealloc = rn.cmt_valid & rn.cmt_dst_we;
        cpr     = rn.cmt_old_pr;
        if (flush) begin
          state_nxt = RECOVER;
          cnt_nxt   = '0;
        end
      end
      RECOVER: begin
        busy = 1'b1;
        cpr  = cnt;
        // A register referenced by the committed map is live; every other one is returned.
        for (int unsigned i = 0; i < NA; i++) begin
          if (cmt_map[i] == cnt) in_cmt = 1'b1;
        end
        dealloc   = ~in_cmt;
        walk_done = (cnt == WP'(NP - 1));
        cnt_nxt   = walk_done ? '0 : cnt + 1'b1;
        if (walk_done) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
      for (int unsigned i = 0; i < NA; i++) begin
        spec_map[i] <= WP'(i);
        cmt_map[i]  <= WP'(i);
      end
    end else if (gwe) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == RUN) begin
        if (alloc)   spec_map[rn.dec_dst] <= rn.fl_next;
        if (dealloc) cmt_map[rn.cmt_arch] <= rn.cmt_new_pr;
      end else if (walk_done) begin
        spec_map <= cmt_map;
      end
    end
  end

  assign rn.dec_ready   = ready;
  assign rn.ren_src1    = spec_map[rn.dec_src1];
  assign rn.ren_src2    = spec_map[rn.dec_src2];
  assign rn.ren_old_dst = spec_map[rn.dec_dst];
  assign rn.ren_dst     = rn.dec_dst_we ? rn.fl_next : '0;
  assign rn.fl_alloc    = alloc;
  assign rn.fl_dealloc  = dealloc;
  assign rn.fl_cpr      = cpr;
  assign rn.fl_flush    = 1'b0;

`ifdef LC4_RENAME_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (gwe && rn.dec_valid && !ready && stall_q != '1) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_lc4_rename_ctrl.sv
// Self-checking bench for lc4_rename_ctrl; the bench plays the free list and keeps a map/free-set reference model.
module tb_lc4_rename_ctrl;
  logic        clk = 1'b0;
  logic        rst, gwe, flush;
  logic        busy;
  logic [15:0] stall_cnt;

  lc4_rename_ctrl_if #(.WA(3), .WP(4)) b ();

  lc4_rename_ctrl #(.NA(8), .NP(16), .WA(3), .WP(4)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .flush(flush),
    .rn(b), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: arch->phys maps, set of free physical registers, recovery position.
  logic [3:0]  m_spec [8];
  logic [3:0]  m_cmt  [8];
  bit          m_rec;
  int          m_cnt;
  logic [15:0] m_free;
  int          m_stall;

  logic        exp_ready, exp_alloc, exp_dealloc, exp_busy;
  logic [3:0]  exp_src1, exp_src2, exp_old, exp_rdst, exp_cpr;
  logic [15:0] exp_stall;

  task automatic drive_fl();
    logic [3:0] nxt;
    nxt = 4'd0;
    for (int i = 0; i < 16; i++) if (m_free[i]) nxt = 4'(i);
    b.fl_full = (m_free == 16'h0);
    b.fl_next = nxt;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_spec[i] = 4'(i);
      m_cmt[i]  = 4'(i);
    end
    m_rec   = 0;
    m_cnt   = 0;
    m_free  = 16'hFF00;
    m_stall = 0;
  endtask

  task automatic model_eval();
    bit live;
    exp_busy  = m_rec;
    exp_ready = !m_rec && !flush && (!b.dec_dst_we || m_free != 16'h0);
    exp_alloc = b.dec_valid && exp_ready && b.dec_dst_we;
    exp_src1  = m_spec[b.dec_src1];
    exp_src2  = m_spec[b.dec_src2];
    exp_old   = m_spec[b.dec_dst];
    exp_rdst  = b.dec_dst_we ? b.fl_next : 4'd0;
    if (!m_rec) begin
      exp_dealloc = b.cmt_valid && b.cmt_dst_we;
      exp_cpr     = b.cmt_old_pr;
    end else begin
      live = 0;
      for (int i = 0; i < 8; i++) if (m_cmt[i] == 4'(m_cnt)) live = 1;
      exp_dealloc = !live;
      exp_cpr     = 4'(m_cnt);
    end
`ifdef LC4_RENAME_STALL_CNT_EN
    exp_stall = 16'(m_stall);
`else
    exp_stall = 16'h0;
`endif
  endtask

  task automatic tick();
    model_eval();
    if (gwe) begin
      if (b.dec_valid && !exp_ready && m_stall < 65535) m_stall++;
      if (!m_rec) begin
        if (exp_alloc) begin
          m_spec[b.dec_dst] = b.fl_next;
          m_free[b.fl_next] = 1'b0;
        end
        if (b.cmt_valid && b.cmt_dst_we) begin
          m_cmt[b.cmt_arch]    = b.cmt_new_pr;
          m_free[b.cmt_old_pr] = 1'b1;
        end
        if (flush) begin
          m_rec = 1;
          m_cnt = 0;
        end
      end else begin
        if (exp_dealloc) m_free[m_cnt] = 1'b1;
        if (m_cnt == 15) begin
          m_spec = m_cmt;
          m_rec  = 0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    drive_fl();
  endtask

  task automatic set_dec(input bit v, input bit we, input int d, input int s1, input int s2);
    b.dec_valid  = v;
    b.dec_dst_we = we;
    b.dec_dst    = 3'(d);
    b.dec_src1   = 3'(s1);
    b.dec_src2   = 3'(s2);
  endtask

  task automatic set_cmt(input bit v, input int arch, input int np, input int op);
    b.cmt_valid  = v;
    b.cmt_dst_we = v;
    b.cmt_arch   = 3'(arch);
    b.cmt_new_pr = 4'(np);
    b.cmt_old_pr = 4'(op);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    gwe   = 1'b1;
    flush = 1'b0;
    set_dec(0, 0, 0, 0, 0);
    set_cmt(0, 0, 0, 0);
    model_reset();
    drive_fl();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    model_eval();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (b.dec_ready !== exp_ready) begin errors++; $display("FAIL reset_ready: got %0b exp %0b", b.dec_ready, exp_ready); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL reset_stall: got %0d exp %0d", stall_cnt, exp_stall); end
    checks++; if (b.fl_flush !== 1'b0) begin errors++; $display("FAIL reset_fl_flush: got %0b exp 0", b.fl_flush); end
    for (int i = 0; i < 8; i++) begin
      set_dec(0, 0, i, i, 7 - i);
      #1;
      model_eval();
      checks++; if (b.ren_src1 !== exp_src1) begin errors++; $display("FAIL reset_map_r%0d: got %0d exp %0d", i, b.ren_src1, exp_src1); end
      checks++; if (b.ren_src2 !== exp_src2) begin errors++; $display("FAIL reset_map2_r%0d: got %0d exp %0d", 7 - i, b.ren_src2, exp_src2); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_rename();
    do_reset();
    set_dec(1, 1, 1, 1, 2);
    #1;
    model_eval();
    checks++; if (b.dec_ready !== exp_ready) begin errors++; $display("FAIL rename_ready: got %0b exp %0b", b.dec_ready, exp_ready); end
    checks++; if (b.ren_src1 !== exp_src1) begin errors++; $display("FAIL rename_src1: got %0d exp %0d", b.ren_src1, exp_src1); end
    checks++; if (b.ren_src2 !== exp_src2) begin errors++; $display("FAIL rename_src2: got %0d exp %0d", b.ren_src2, exp_src2); end
    checks++; if (b.ren_old_dst !== exp_old) begin errors++; $display("FAIL rename_old: got %0d exp %0d", b.ren_old_dst, exp_old); end
    checks++; if (b.ren_dst !== exp_rdst) begin errors++; $display("FAIL rename_dst: got %0d exp %0d", b.ren_dst, exp_rdst); end
    checks++; if (b.fl_alloc !== exp_alloc) begin errors++; $display("FAIL rename_alloc: got %0b exp %0b", b.fl_alloc, exp_alloc); end
    tick();
    set_dec(1, 0, 0, 1, 2);
    #1;
    model_eval();
    checks++; if (b.ren_src1 !== exp_src1) begin errors++; $display("FAIL rename_next_r1: got %0d exp %0d", b.ren_src1, exp_src1); end
    checks++; if (b.ren_dst !== exp_rdst) begin errors++; $display("FAIL rename_store_dst: got %0d exp %0d", b.ren_dst, exp_rdst); end
    tick();
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_dec(1, 1, i, i, 0);
      #1;
      model_eval();
      checks++; if (b.fl_alloc !== exp_alloc) begin errors++; $display("FAIL exhaust_alloc%0d: got %0b exp %0b", i, b.fl_alloc, exp_alloc); end
      checks++; if (b.ren_dst !== exp_rdst) begin errors++; $display("FAIL exhaust_dst%0d: got %0d exp %0d", i, b.ren_dst, exp_rdst); end
      tick();
    end
    set_dec(1, 1, 3, 0, 0);
    #1;
    model_eval();
    checks++; if (b.dec_ready !== exp_ready) begin errors++; $display("FAIL full_ready: got %0b exp %0b", b.dec_ready, exp_ready); end
    checks++; if (b.fl_alloc !== exp_alloc) begin errors++; $display("FAIL full_alloc: got %0b exp %0b", b.fl_alloc, exp_alloc); end
    tick();
    set_dec(1, 0, 3, 0, 0);
    #1;
    model_eval();
    checks++; if (b.dec_ready !== exp_ready) begin errors++; $display("FAIL full_store_ready: got %0b exp %0b", b.dec_ready, exp_ready); end
    checks++; if (b.fl_alloc !== exp_alloc) begin errors++; $display("FAIL full_store_alloc: got %0b exp %0b", b.fl_alloc, exp_alloc); end
    tick();
  endtask

  task automatic test_commit_flush();
    do_reset();
    set_dec(1, 1, 1, 1, 2);
    tick();
    set_dec(1, 1, 2, 2, 2);
    tick();
    set_dec(0, 0, 0, 0, 0);
    set_cmt(1, 1, 15, 1);
    #1;
    model_eval();
    checks++; if (b.fl_dealloc !== exp_dealloc) begin errors++; $display("FAIL commit_dealloc: got %0b exp %0b", b.fl_dealloc, exp_dealloc); end
    checks++; if (b.fl_cpr !== exp_cpr) begin errors++; $display("FAIL commit_cpr: got %0d exp %0d", b.fl_cpr, exp_cpr); end
    tick();
    set_cmt(0, 0, 0, 0);
    set_dec(1, 1, 3, 0, 0);
    flush = 1'b1;
    #1;
    model_eval();
    checks++; if (b.dec_ready !== exp_ready) begin errors++; $display("FAIL flush_ready: got %0b exp %0b", b.dec_ready, exp_ready); end
    checks++; if (b.fl_alloc !== exp_alloc) begin errors++; $display("FAIL flush_alloc: got %0b exp %0b", b.fl_alloc, exp_alloc); end
    tick();
    flush = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      model_eval();
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL walk_busy%0d: got %0b exp %0b", c, busy, exp_busy); end
      checks++; if (b.dec_ready !== exp_ready) begin errors++; $display("FAIL walk_ready%0d: got %0b exp %0b", c, b.dec_ready, exp_ready); end
      checks++; if (b.fl_dealloc !== exp_dealloc) begin errors++; $display("FAIL walk_dealloc%0d: got %0b exp %0b", c, b.fl_dealloc, exp_dealloc); end
      checks++; if (b.fl_cpr !== exp_cpr) begin errors++; $display("FAIL walk_cpr%0d: got %0d exp %0d", c, b.fl_cpr, exp_cpr); end
      tick();
    end
    set_dec(1, 0, 0, 2, 1);
    #1;
    model_eval();
    checks++; if (b.ren_src1 !== exp_src1) begin errors++; $display("FAIL recov_r2: got %0d exp %0d", b.ren_src1, exp_src1); end
    checks++; if (b.ren_src2 !== exp_src2) begin errors++; $display("FAIL recov_r1: got %0d exp %0d", b.ren_src2, exp_src2); end
    checks++; if (b.dec_ready !== exp_ready) begin errors++; $display("FAIL recov_ready: got %0b exp %0b", b.dec_ready, exp_ready); end
    checks++; if (busy !== exp_busy) begin errors++; $display("FAIL recov_busy: got %0b exp %0b", busy, exp_busy); end
    tick();
  endtask

  task automatic test_reset_mid_recover();
    do_reset();
    set_dec(1, 1, 1, 0, 0);
    tick();
    set_dec(0, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    model_reset();
    drive_fl();
    set_dec(1, 1, 1, 1, 0);
    #1;
    model_eval();
    checks++; if (busy !== exp_busy) begin errors++; $display("FAIL midrst_busy: got %0b exp %0b", busy, exp_busy); end
    checks++; if (b.ren_src1 !== exp_src1) begin errors++; $display("FAIL midrst_r1: got %0d exp %0d", b.ren_src1, exp_src1); end
    checks++; if (b.dec_ready !== exp_ready) begin errors++; $display("FAIL midrst_ready: got %0b exp %0b", b.dec_ready, exp_ready); end
    @(negedge clk);
    rst = 1'b1;
    set_dec(0, 0, 0, 0, 0);
    #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_dec(1, 1, 3, 0, 0);
    tick();
    set_dec(1, 1, 4, 0, 0);
    tick();
    set_dec(1, 1, 3, 3, 4);
    set_cmt(1, 3, 15, 3);
    #1;
    model_eval();
    checks++; if (b.fl_alloc !== exp_alloc) begin errors++; $display("FAIL simul_alloc: got %0b exp %0b", b.fl_alloc, exp_alloc); end
    checks++; if (b.ren_dst !== exp_rdst) begin errors++; $display("FAIL simul_dst: got %0d exp %0d", b.ren_dst, exp_rdst); end
    checks++; if (b.fl_dealloc !== exp_dealloc) begin errors++; $display("FAIL simul_dealloc: got %0b exp %0b", b.fl_dealloc, exp_dealloc); end
    checks++; if (b.fl_cpr !== exp_cpr) begin errors++; $display("FAIL simul_cpr: got %0d exp %0d", b.fl_cpr, exp_cpr); end
    tick();
    gwe = 1'b0;
    set_dec(1, 1, 3, 3, 4);
    set_cmt(1, 4, 14, 4);
    tick();
    gwe = 1'b1;
    set_dec(0, 0, 0, 3, 4);
    set_cmt(0, 0, 0, 0);
    #1;
    model_eval();
    checks++; if (b.ren_src1 !== exp_src1) begin errors++; $display("FAIL gwe0_r3: got %0d exp %0d", b.ren_src1, exp_src1); end
    checks++; if (b.ren_src2 !== exp_src2) begin errors++; $display("FAIL gwe0_r4: got %0d exp %0d", b.ren_src2, exp_src2); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      gwe   = ($urandom_range(9) != 0);
      flush = ($urandom_range(39) == 0);
      set_dec($urandom_range(1), $urandom_range(1), $urandom_range(7), $urandom_range(7), $urandom_range(7));
      set_cmt($urandom_range(1), $urandom_range(7), $urandom_range(15), $urandom_range(15));
      #1;
      model_eval();
      checks++; if (b.dec_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %0b exp %0b", n, b.dec_ready, exp_ready); end
      checks++; if (b.ren_src1 !== exp_src1 || b.ren_src2 !== exp_src2 || b.ren_old_dst !== exp_old) begin
        errors++; $display("FAIL rnd_map@%0d: got %0d/%0d/%0d exp %0d/%0d/%0d", n, b.ren_src1, b.ren_src2, b.ren_old_dst, exp_src1, exp_src2, exp_old);
      end
      checks++; if (b.ren_dst !== exp_rdst) begin errors++; $display("FAIL rnd_dst@%0d: got %0d exp %0d", n, b.ren_dst, exp_rdst); end
      checks++; if (b.fl_alloc !== exp_alloc) begin errors++; $display("FAIL rnd_alloc@%0d: got %0b exp %0b", n, b.fl_alloc, exp_alloc); end
      checks++; if (b.fl_dealloc !== exp_dealloc) begin errors++; $display("FAIL rnd_dealloc@%0d: got %0b exp %0b", n, b.fl_dealloc, exp_dealloc); end
      if (exp_dealloc) begin
        checks++; if (b.fl_cpr !== exp_cpr) begin errors++; $display("FAIL rnd_cpr@%0d: got %0d exp %0d", n, b.fl_cpr, exp_cpr); end
      end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy@%0d: got %0b exp %0b", n, busy, exp_busy); end
      checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %0d exp %0d", n, stall_cnt, exp_stall); end
      tick();
    end
    gwe   = 1'b1;
    flush = 1'b0;
  endtask

`ifdef LC4_RENAME_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_dec(1, 1, i, 0, 0);
      tick();
    end
    set_dec(1, 1, 2, 0, 0);
    repeat (5) tick();
    #1;
    model_eval();
    checks++; if (stall_cnt !== exp_stall || exp_stall !== 16'd5) begin errors++; $display("FAIL stall_5: got %0d exp %0d", stall_cnt, exp_stall); end
    repeat (70000) tick();
    #1;
    model_eval();
    checks++; if (stall_cnt !== exp_stall || exp_stall !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %0h exp %0h", stall_cnt, exp_stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_rename();
    test_exhaust();
    test_commit_flush();
    test_reset_mid_recover();
    test_back_to_back();
    test_random();
`ifdef LC4_RENAME_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
